// File: rtl/iwm_pkg.sv
// Shared IWM definitions: write-state encoding, default bit-cell length and
// handshake bit positions used by the register decode.
package iwm_pkg;

    localparam int CELL_CLKS_DEFAULT = 16;

    // Positions of the write handshake bits in the IWM status/handshake byte
    localparam int IWM_BUSY_BIT     = 7;
    localparam int IWM_UNDERRUN_BIT = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_SHIFT    = 2'd2,
        ST_UNDERRUN = 2'd3
    } wr_state_e;

    function automatic logic [7:0] iwm_handshake_byte(input logic busy_n,
                                                      input logic underrun_n);
        logic [7:0] hs;
        hs                   = 8'h3F;
        hs[IWM_BUSY_BIT]     = busy_n;
        hs[IWM_UNDERRUN_BIT] = underrun_n;
        return hs;
    endfunction

endpackage

// File: rtl/iwm_bit_timer.sv
// Bit-cell timer for the IWM write serializer. Cell length is latched on
// start so a mode change only affects cells of the next byte.
module iwm_bit_timer
    import iwm_pkg::*;
#(
    parameter int CELL_CLKS = CELL_CLKS_DEFAULT
) (
    input  logic clk8,
    input  logic reset,
    input  logic start,
    input  logic fast,
    output logic cellStart
);

    localparam int CW = $clog2(2 * CELL_CLKS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          fast_q, fast_d;
    logic [CW-1:0] last_s;

    // Terminal count for the latched cell length
    always_comb begin
        if (fast_q) begin
            last_s = CW'(CELL_CLKS - 1);
        end else begin
            last_s = CW'(2 * CELL_CLKS - 1);
        end
    end

    // Counter restarts at zero on start; otherwise wraps every cell
    always_comb begin
        cnt_d  = cnt_q;
        fast_d = fast_q;
        if (start) begin
            cnt_d  = '0;
            fast_d = fast;
        end else if (cnt_q == last_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Timer state register
    always_ff @(posedge clk8) begin
        if (reset) begin
            cnt_q  <= '0;
            fast_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            fast_q <= fast_d;
        end
    end

    // High in the last clock of a cell: the next edge opens a new cell
    assign cellStart = (cnt_q == last_s);

endmodule

// File: rtl/iwm_write_serializer.sv
// IWM write serializer: CPU byte buffer, MSB-first flux serializer and write
// handshake. Optional byte tap enabled by defining IWM_BYTE_TAP_EN.
module iwm_write_serializer
    import iwm_pkg::*;
#(
    parameter int CELL_CLKS = CELL_CLKS_DEFAULT
) (
    input  logic       clk8,
    input  logic       reset,
    input  logic       writeMode,
    input  logic       fastCell,
    input  logic       dataWrite,
    input  logic [7:0] dataIn,
    output logic       wrData,
    output logic       _iwmBusy,
    output logic       _writeUnderrun,
    output logic       writeActive
`ifdef IWM_BYTE_TAP_EN
    ,
    output logic [7:0] byteOut,
    output logic       byteOutValid
`endif
);

    wr_state_e  state_q, state_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       wr_data_q, wr_data_d;
    logic       underrun_n_q, underrun_n_d;
    logic       load_s;
    logic       byte_done_s;
    logic       cell_start_s;

    iwm_bit_timer #(
        .CELL_CLKS (CELL_CLKS)
    ) u_timer (
        .clk8      (clk8),
        .reset     (reset),
        .start     (load_s),
        .fast      (fastCell),
        .cellStart (cell_start_s)
    );

    // Next-state, buffer and shifter logic
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        wr_data_d    = wr_data_q;
        underrun_n_d = underrun_n_q;
        load_s       = 1'b0;
        byte_done_s  = 1'b0;

        if (!writeMode) begin
            // Session ends: abort any byte in flight, flux line holds its level
            state_d      = ST_IDLE;
            buf_d        = 8'h00;
            buf_full_d   = 1'b0;
            underrun_n_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (buf_full_q) begin
                        load_s  = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_SHIFT: begin
                    if (cell_start_s) begin
                        if (bit_idx_q == 3'd7) begin
                            byte_done_s = 1'b1;
                            if (buf_full_q) begin
                                load_s = 1'b1;
                            end else begin
                                state_d      = ST_UNDERRUN;
                                underrun_n_d = 1'b0;
                            end
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_idx_d = bit_idx_q + 3'd1;
                            wr_data_d = wr_data_q ^ shift_q[6];
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                ST_UNDERRUN: begin
                    state_d = ST_UNDERRUN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // A load opens bit 7's cell, so its transition lands on the load edge
            if (load_s) begin
                shift_d    = buf_q;
                bit_idx_d  = 3'd0;
                buf_full_d = 1'b0;
                wr_data_d  = wr_data_q ^ buf_q[7];
            end else begin
                bit_idx_d = bit_idx_d;
            end

            // A slot being emptied on this edge can take the new byte at once
            if (dataWrite && ((state_q == ST_ARMED) || (state_q == ST_SHIFT)) &&
                (!buf_full_q || load_s)) begin
                buf_d      = dataIn;
                buf_full_d = 1'b1;
            end else begin
                buf_d = buf_d;
            end
        end
    end

    // Serializer state registers
    always_ff @(posedge clk8) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            buf_q        <= 8'h00;
            buf_full_q   <= 1'b0;
            shift_q      <= 8'h00;
            bit_idx_q    <= 3'd0;
            wr_data_q    <= 1'b0;
            underrun_n_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            wr_data_q    <= wr_data_d;
            underrun_n_q <= underrun_n_d;
        end
    end

    assign wrData         = wr_data_q;
    assign _iwmBusy       = ~buf_full_q;
    assign _writeUnderrun = underrun_n_q;
    assign writeActive    = (state_q == ST_SHIFT);

`ifdef IWM_BYTE_TAP_EN
    logic [7:0] cur_byte_q, cur_byte_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic       byte_valid_q, byte_valid_d;

    // Remember the byte in flight and publish it when its last cell closes
    always_comb begin
        byte_valid_d = byte_done_s;
        if (load_s) begin
            cur_byte_d = buf_q;
        end else begin
            cur_byte_d = cur_byte_q;
        end
        if (byte_done_s) begin
            byte_out_d = cur_byte_q;
        end else begin
            byte_out_d = byte_out_q;
        end
    end

    // Byte tap registers
    always_ff @(posedge clk8) begin
        if (reset) begin
            cur_byte_q   <= 8'h00;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
        end else begin
            cur_byte_q   <= cur_byte_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    assign byteOut      = byte_out_q;
    assign byteOutValid = byte_valid_q;
`endif

endmodule

// File: tb/tb_iwm_write_serializer.sv
// Self-checking bench for iwm_write_serializer; covers the byte tap when
// IWM_BYTE_TAP_EN is defined.
module tb_iwm_write_serializer;

    logic       clk8 = 1'b0;
    logic       reset;
    logic       writeMode;
    logic       fastCell;
    logic       dataWrite;
    logic [7:0] dataIn;
    logic       wr_data;
    logic       iwm_busy_n;
    logic       write_underrun_n;
    logic       write_active;
`ifdef IWM_BYTE_TAP_EN
    logic [7:0] byte_out;
    logic       byte_out_valid;
`endif

    int checks = 0;
    int errors = 0;
    logic model_wr = 1'b0;

    iwm_write_serializer dut (
        .clk8           (clk8),
        .reset          (reset),
        .writeMode      (writeMode),
        .fastCell       (fastCell),
        .dataWrite      (dataWrite),
        .dataIn         (dataIn),
        .wrData         (wr_data),
        ._iwmBusy       (iwm_busy_n),
        ._writeUnderrun (write_underrun_n),
        .writeActive    (write_active)
`ifdef IWM_BYTE_TAP_EN
        ,
        .byteOut        (byte_out),
        .byteOutValid   (byte_out_valid)
`endif
    );

    always #5 clk8 = ~clk8;

    typedef struct {
        logic       fast;
        logic [7:0] b0;
        int         nb;
        logic [7:0] b1;
        int         t2;
        logic [7:0] b2;
        int         t3;
        logic       flip;
        int         exp_toggles;
        int         exp_end;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk8);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         c;
        int         end_e;
        int         bad;
        int         tog;
        int         k;
        int         pulses;
        logic       prev;
        logic [15:0] bits;
        c      = v.fast ? 16 : 32;
        end_e  = 1 + v.nb * 8 * c;
        bits   = {v.b0, v.b1};
        bad    = 0;
        tog    = 0;
        pulses = 0;
        fastCell  = v.fast;
        writeMode = 1'b1;
        tick();
        tick();
        dataIn    = v.b0;
        dataWrite = 1'b1;
        tick();
        dataWrite = 1'b0;
        check($sformatf("busy_after_write[%0d]", idx), iwm_busy_n, 1'b0);
        prev = wr_data;
        for (int e = 1; e <= v.exp_end; e++) begin
            if (v.nb > 1 && e == v.t2) begin
                dataIn    = v.b1;
                dataWrite = 1'b1;
            end else if (v.t3 > 0 && e == v.t3) begin
                dataIn    = v.b2;
                dataWrite = 1'b1;
            end
            tick();
            dataWrite = 1'b0;
            if (v.flip && e == 1) fastCell = ~v.fast;
            k = (e - 1) / c;
            if (((e - 1) % c) == 0 && k < v.nb * 8 && bits[15 - k]) model_wr = ~model_wr;
            if (wr_data !== model_wr) bad++;
            if (wr_data !== prev) tog++;
            prev = wr_data;
            if (write_active !== (e < end_e)) bad++;
            if (e == 1) begin
                check($sformatf("busy_after_load[%0d]", idx), iwm_busy_n,
                      (v.nb > 1 && v.t2 == 1) ? 1'b0 : 1'b1);
                check($sformatf("active_after_load[%0d]", idx), write_active, 1'b1);
            end
            if (e == v.exp_end - 1) check($sformatf("active_before_end[%0d]", idx), write_active, 1'b1);
`ifdef IWM_BYTE_TAP_EN
            begin
                logic exp_valid;
                exp_valid = (e > 1) && (((e - 1) % (8 * c)) == 0) && (((e - 1) / (8 * c)) <= v.nb);
                if (byte_out_valid !== exp_valid) bad++;
                if (byte_out_valid) pulses++;
                if (exp_valid && byte_out !== ((((e - 1) / (8 * c)) == 1) ? v.b0 : v.b1)) bad++;
            end
`endif
        end
        check($sformatf("cell_sequence_errors[%0d]", idx), bad, 0);
        check($sformatf("toggles[%0d]", idx), tog, v.exp_toggles);
        check($sformatf("underrun_at_end[%0d]", idx), write_underrun_n, 1'b0);
        check($sformatf("inactive_at_end[%0d]", idx), write_active, 1'b0);
`ifdef IWM_BYTE_TAP_EN
        check($sformatf("tap_pulses[%0d]", idx), pulses, v.nb);
`endif
        // Underrun must freeze the flux line and ignore writes
        dataIn    = 8'hFF;
        dataWrite = 1'b1;
        tick();
        dataWrite = 1'b0;
        repeat (20) tick();
        check($sformatf("wr_frozen[%0d]", idx), wr_data, model_wr);
        check($sformatf("busy_in_underrun[%0d]", idx), iwm_busy_n, 1'b1);
        writeMode = 1'b0;
        tick();
        check($sformatf("underrun_clear[%0d]", idx), write_underrun_n, 1'b1);
        check($sformatf("idle_inactive[%0d]", idx), write_active, 1'b0);
    endtask

    initial begin
        //         fast  b0     nb b1     t2   b2     t3  flip tog end
        vecs[0] = '{1'b1, 8'hFF, 1, 8'h00, 0,   8'h00, 0,  1'b0, 8, 129};
        vecs[1] = '{1'b1, 8'hD5, 2, 8'hAA, 100, 8'h00, 0,  1'b0, 9, 257};
        vecs[2] = '{1'b1, 8'h96, 1, 8'h00, 0,   8'h00, 0,  1'b1, 4, 129};
        vecs[3] = '{1'b1, 8'h5A, 2, 8'h11, 5,   8'h22, 10, 1'b0, 6, 257};
        vecs[4] = '{1'b0, 8'h80, 1, 8'h00, 0,   8'h00, 0,  1'b0, 1, 257};
        vecs[5] = '{1'b1, 8'h3C, 2, 8'hC3, 1,   8'h00, 0,  1'b0, 8, 257};
        vecs[6] = '{1'b1, 8'h01, 2, 8'h00, 128, 8'h00, 0,  1'b0, 1, 257};
        vecs[7] = '{1'b0, 8'hA5, 2, 8'h0F, 200, 8'h00, 0,  1'b0, 8, 513};

        reset     = 1'b1;
        writeMode = 1'b0;
        fastCell  = 1'b1;
        dataWrite = 1'b0;
        dataIn    = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_wrData", wr_data, 1'b0);
        check("reset_busy", iwm_busy_n, 1'b1);
        check("reset_underrun", write_underrun_n, 1'b1);
        check("reset_active", write_active, 1'b0);
`ifdef IWM_BYTE_TAP_EN
        check("reset_tap_valid", byte_out_valid, 1'b0);
        check("reset_tap_byte", byte_out, 8'h00);
`endif

        dataIn    = 8'h5A;
        dataWrite = 1'b1;
        tick();
        dataWrite = 1'b0;
        check("idle_write_ignored", iwm_busy_n, 1'b1);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a byte
        begin
            int pulses;
            pulses    = 0;
            fastCell  = 1'b1;
            writeMode = 1'b1;
            tick();
            tick();
            dataIn    = 8'hD5;
            dataWrite = 1'b1;
            tick();
            dataWrite = 1'b0;
            dataIn    = 8'hAA;
            dataWrite = 1'b1;
            tick();
            dataWrite = 1'b0;
            repeat (58) tick();
            reset = 1'b1;
            tick();
            reset    = 1'b0;
            model_wr = 1'b0;
            check("midreset_wrData", wr_data, 1'b0);
            check("midreset_busy", iwm_busy_n, 1'b1);
            check("midreset_underrun", write_underrun_n, 1'b1);
            check("midreset_active", write_active, 1'b0);
`ifdef IWM_BYTE_TAP_EN
            check("midreset_tap_byte", byte_out, 8'h00);
            for (int e = 0; e < 200; e++) begin
                tick();
                if (byte_out_valid) pulses++;
            end
            check("midreset_no_pulse", pulses, 0);
`else
            repeat (200) tick();
`endif
            check("midreset_stays_armed", write_active, 1'b0);
            writeMode = 1'b0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iwm_write_serializer.md
# iwm_write_serializer

Write-side companion to the IWM read latch: accepts CPU data bytes through the IWM data register (Q7=1, Q6=1, drive enabled) and serializes them MSB-first onto the floppy write-data line, one bit cell at a time, with a 1 encoded as a transition and a 0 as no transition. It supplies the handshake register bits `_iwmBusy` (buffer empty) and `_writeUnderrun` seen by the CPU, and sits between the IWM register decode and the `floppy` drive models.

## Interface
- `CELL_CLKS`, 16, clk8 cycles per bit cell in fast mode (2 µs); slow mode uses 2×CELL_CLKS.
- `clk8`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `writeMode`  in  1  Q7 & Q6 & (diskEnableInt | diskEnableExt); level.
- `fastCell`  in  1  iwmMode C bit; 1 = CELL_CLKS per bit, 0 = 2×CELL_CLKS.
- `dataWrite`  in  1  one-cycle strobe: CPU wrote the data register.
- `dataIn`  in  8  byte accompanying `dataWrite`.
- `wrData`  out  1  serial flux line to drives; toggles for each 1 bit.
- `_iwmBusy`  out  1  1 = holding buffer empty, CPU may write.
- `_writeUnderrun`  out  1  0 = underrun occurred in this write session.
- `writeActive`  out  1  1 while a byte is being shifted.

## Operation
- Resources: 8-bit holding buffer + `bufFull`; 8-bit shift register; 3-bit bit index; cell counter; state.
- States: IDLE, ARMED, SHIFT, UNDERRUN.
- IDLE: `writeMode`=0. `dataWrite` ignored; buffer cleared. `writeMode`=1 → ARMED.
- ARMED: waits for `bufFull`; then loads shifter from buffer, clears `bufFull`, → SHIFT.
- SHIFT: at the first clock of each cell, if current bit = 1, `wrData` toggles. After 8 cells, at the byte boundary: `bufFull` → load next byte, stay SHIFT; else → UNDERRUN, `_writeUnderrun`=0.
- UNDERRUN: no shifting, `wrData` holds; writes ignored; leaves only when `writeMode` falls.
- `writeMode` falling in any state → IDLE next edge; the byte in flight is aborted; buffer cleared; `_writeUnderrun` returns to 1.
- Buffer write: `dataWrite` in ARMED/SHIFT with `bufFull`=0 captures `dataIn`, sets `bufFull`. Write while `bufFull`=1 is dropped; buffer unchanged.
- Simultaneous load and `dataWrite` at the same edge: shifter takes the old buffer byte, the new byte is captured, `bufFull` stays 1.
- `fastCell` is sampled at each byte load; a change mid-byte takes effect at the next byte.
- `_iwmBusy` = ~`bufFull`; `writeActive` = (state == SHIFT).

## Timing
- Reset values: `wrData`=0, `_iwmBusy`=1, `_writeUnderrun`=1, `writeActive`=0, state IDLE, `bufFull`=0.
- In ARMED, strobe sampled at edge N: `bufFull`=1 after N; load at N+1 (`_iwmBusy`=1, `writeActive`=1 after N+1); bit 7 transition (if 1) visible after N+1.
- Bit k (k=0 → D7) cell starts at N+1+k·C, C = cell length.
- Byte boundary at N+1+8C: next load or UNDERRUN entry on that edge; back-to-back bytes have no gap cells.
- CPU deadline: next byte must be strobed by edge N+8C to avoid underrun.
- Reset asserted mid-byte: all outputs return to reset values on the next edge.

## Configuration
- `IWM_BYTE_TAP_EN` defined: adds outputs `byteOut` (8) and `byteOutValid` (1). `byteOutValid` pulses for one cycle at each completed byte boundary, with `byteOut` = byte just shifted; the disk-image writer stores bytes without flux decode. Aborted bytes produce no pulse. Reset: both 0.
- Not defined: ports and tap logic absent; serial behaviour identical.

## Structure
- Shared package `iwm_pkg`: state enum (IDLE/ARMED/SHIFT/UNDERRUN), default cell length constant, IWM handshake bit positions (busy = bit 7, underrun = bit 6) for use by the register decode.
- One sub-module `iwm_bit_timer`: cell counter with `start`, `fast` inputs and a one-cycle `cellStart` pulse; the serializer state machine remains in the top.

## Test plan
- Fast mode, write 0xFF in ARMED at edge N → `wrData` toggles at N+1, N+17, …, N+113 (8 toggles); `_iwmBusy`=1 from N+1.
- Write 0xD5, then 0xAA before N+128 → pattern 11010101 10101010 with no gap; `_writeUnderrun` stays 1.
- Single byte 0x96, no second write → UNDERRUN at N+129, `_writeUnderrun`=0, `wrData` frozen; drop `writeMode` → `_writeUnderrun`=1, IDLE.
- Two writes while `bufFull`=1 (0x11, then 0x22) → 0x22 dropped; shifted sequence contains only 0x11.
- Slow mode (`fastCell`=0), write 0x80 → one toggle at N+1, byte boundary at N+257.
- `IWM_BYTE_TAP_EN` with bytes 0xD5, 0xAA → `byteOutValid` pulses at N+129 (0xD5) and N+257 (0xAA); `reset` at N+60 → no pulse, all outputs at reset values.
